vga_pattern_gen: RTL and testbench

//  Parametrised multi-mode VGA test-pattern source; successor to the single-pattern colour-bar source.

---
 rtl/vga_pattern_gen.sv | 200 ++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: multi-mode VGA test-pattern source.
// Sits behind the VGA timing generator and turns its i_rd / i_newline /
// i_newframe strobes into a registered {R,G,B} pixel stream. Four patterns:
// colour bars, an animated gray ramp, a checkerboard and a frame-cycled
// solid colour. Tracks pixel/line position and an 8-bit frame counter.
//
// Optional feature: define VGATEST_BORDER_EN to force a one-pixel white
// border (first/last column, first/last line) on top of every pattern.
//
// NBARS_LG must be at least 3: the bar colour is taken from the top three
// bits of the bar index.
module vga_pattern_gen #(
    parameter int BITS_PER_COLOR = 8,
    parameter int HW             = 12,
    parameter int VW             = 12,
    parameter int NBARS_LG       = 3,
    parameter int CHK_LG         = 4
) (
    input  logic                          i_pixclk,
    input  logic                          i_reset,
    input  logic [HW-1:0]                 i_width,
    input  logic [VW-1:0]                 i_height,
    input  logic [1:0]                    i_mode,
    input  logic                          i_rd,
    input  logic                          i_newline,
    input  logic                          i_newframe,
    output logic [3*BITS_PER_COLOR-1:0]   o_pixel,
    output logic [7:0]                    o_frame
);

    localparam int PW = 3 * BITS_PER_COLOR;

    localparam logic [HW-1:0]       H_ZERO   = {HW{1'b0}};
    localparam logic [HW-1:0]       H_ONE    = {{(HW-1){1'b0}}, 1'b1};
    localparam logic [VW-1:0]       V_ZERO   = {VW{1'b0}};
    localparam logic [VW-1:0]       V_ONE    = {{(VW-1){1'b0}}, 1'b1};
    localparam logic [NBARS_LG-1:0] NB_ZERO  = {NBARS_LG{1'b0}};
    localparam logic [NBARS_LG-1:0] NB_ONE   = {{(NBARS_LG-1){1'b0}}, 1'b1};
    localparam logic [NBARS_LG-1:0] HBAR_MAX = {NBARS_LG{1'b1}};
    localparam logic [PW-1:0]       PIX_WHITE = {PW{1'b1}};
    localparam logic [PW-1:0]       PIX_BLACK = {PW{1'b0}};

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_RAMP    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_SOLID   = 2'd3
    } mode_e;

    // Eight-entry colour table shared by the bar and solid-colour patterns.
    function automatic logic [PW-1:0] color_lut(input logic [2:0] idx);
        logic [BITS_PER_COLOR-1:0] f;
        logic [BITS_PER_COLOR-1:0] z;
        f = {BITS_PER_COLOR{1'b1}};
        z = {BITS_PER_COLOR{1'b0}};
        case (idx)
            3'd0:    color_lut = {f, f, f};  // white
            3'd1:    color_lut = {f, f, z};  // yellow
            3'd2:    color_lut = {z, f, f};  // cyan
            3'd3:    color_lut = {z, f, z};  // green
            3'd4:    color_lut = {f, z, f};  // magenta
            3'd5:    color_lut = {f, z, z};  // red
            3'd6:    color_lut = {z, z, f};  // blue
            default: color_lut = {z, z, z};  // black
        endcase
    endfunction

    logic [HW-1:0]       hpos_q,  hpos_d;
    logic [VW-1:0]       ypos_q,  ypos_d;
    logic [NBARS_LG-1:0] hbar_q,  hbar_d;
    logic [HW-1:0]       hedge_q, hedge_d;
    logic                dline_q, dline_d;
    mode_e               mode_q,  mode_d;
    logic [7:0]          frame_q, frame_d;
    logic [PW-1:0]       pixel_q, pixel_d;

    logic [HW-1:0]             barw_s;
    logic [HW-1:0]             hpos_inc_s;
    logic [BITS_PER_COLOR-1:0] ramp_s;
    logic                      chk_s;
    logic [PW-1:0]             base_s;
    logic [PW-1:0]             pattern_s;

    // Bar width is re-derived from i_width at every line start.
    assign barw_s     = i_width >> NBARS_LG;
    assign hpos_inc_s = hpos_q + H_ONE;
    assign ramp_s     = BITS_PER_COLOR'(hpos_q) + BITS_PER_COLOR'(frame_q);
    assign chk_s      = hpos_q[CHK_LG] ^ ypos_q[CHK_LG] ^ frame_q[0];

    // Select the pattern colour for the current position from the latched mode.
    always_comb begin
        base_s = PIX_BLACK;
        case (mode_q)
            MODE_BARS:    base_s = color_lut(hbar_q[NBARS_LG-1 -: 3]);
            MODE_RAMP:    base_s = {ramp_s, ramp_s, ramp_s};
            MODE_CHECKER: begin
                if (chk_s) begin
                    base_s = PIX_WHITE;
                end else begin
                    base_s = PIX_BLACK;
                end
            end
            MODE_SOLID:   base_s = color_lut(frame_q[7:5]);
            default:      base_s = PIX_BLACK;
        endcase
    end

`ifdef VGATEST_BORDER_EN
    logic border_s;
    // The border sits on the first/last active column and line of the frame.
    assign border_s  = (hpos_q == H_ZERO) || (hpos_q == i_width - H_ONE) ||
                       (ypos_q == V_ZERO) || (ypos_q == i_height - V_ONE);
    assign pattern_s = border_s ? PIX_WHITE : base_s;
`else
    logic unused_height_s;
    // Frame height only matters for the border; keep it visibly consumed.
    assign unused_height_s = ^i_height;
    assign pattern_s       = base_s;
`endif

    // Next-state decode of the strobes: newframe beats newline beats rd.
    always_comb begin
        hpos_d  = hpos_q;
        ypos_d  = ypos_q;
        hbar_d  = hbar_q;
        hedge_d = hedge_q;
        dline_d = dline_q;
        mode_d  = mode_q;
        frame_d = frame_q;
        pixel_d = pixel_q;
        if (i_newframe) begin
            ypos_d  = V_ZERO;
            mode_d  = mode_e'(i_mode);
            frame_d = frame_q + 8'd1;
            hpos_d  = H_ZERO;
            hbar_d  = NB_ZERO;
            hedge_d = barw_s;
            dline_d = 1'b0;
            pixel_d = PIX_BLACK;
        end else if (i_newline) begin
            hpos_d  = H_ZERO;
            hbar_d  = NB_ZERO;
            hedge_d = barw_s;
            dline_d = 1'b0;
            pixel_d = PIX_BLACK;
            // Lines that never saw a pixel request are blanking, not video.
            if (dline_q) begin
                ypos_d = ypos_q + V_ONE;
            end else begin
                ypos_d = ypos_q;
            end
        end else if (i_rd) begin
            pixel_d = pattern_s;
            hpos_d  = hpos_inc_s;
            dline_d = 1'b1;
            // A zero edge means the line is narrower than the bar count:
            // there are no bar boundaries, so the bar index stays at zero.
            if ((hedge_q != H_ZERO) && (hpos_inc_s == hedge_q)) begin
                hedge_d = hedge_q + barw_s;
                if (hbar_q != HBAR_MAX) begin
                    hbar_d = hbar_q + NB_ONE;
                end else begin
                    hbar_d = hbar_q;
                end
            end else begin
                hedge_d = hedge_q;
                hbar_d  = hbar_q;
            end
        end else begin
            pixel_d = pixel_q;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            hpos_q  <= H_ZERO;
            ypos_q  <= V_ZERO;
            hbar_q  <= NB_ZERO;
            hedge_q <= H_ZERO;
            dline_q <= 1'b0;
            mode_q  <= MODE_BARS;
            frame_q <= 8'd0;
            pixel_q <= PIX_BLACK;
        end else begin
            hpos_q  <= hpos_d;
            ypos_q  <= ypos_d;
            hbar_q  <= hbar_d;
            hedge_q <= hedge_d;
            dline_q <= dline_d;
            mode_q  <= mode_d;
            frame_q <= frame_d;
            pixel_q <= pixel_d;
        end
    end

    assign o_pixel = pixel_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen (default parameters, 8 bits per colour).
// Directed table vectors, hand-written strobe/reset sequences and randomized
// frames, all checked against a position-based reference model.
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] width;
    logic [11:0] height;
    logic [1:0]  mode;
    logic        rd;
    logic        nl;
    logic        nf;
    logic [23:0] pix;
    logic [7:0]  frame;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the screen position should be.
    int          m_frame;
    int          m_mode;
    int          m_x;
    int          m_y;
    int          m_barw;
    bit          m_dline;
    logic [23:0] m_pix;

    typedef struct {
        string       name;
        int          mode;
        int          frame;
        int          width;
        int          x;
        int          y;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[$];

    vga_pattern_gen dut (
        .i_pixclk  (clk),
        .i_reset   (rst),
        .i_width   (width),
        .i_height  (height),
        .i_mode    (mode),
        .i_rd      (rd),
        .i_newline (nl),
        .i_newframe(nf),
        .o_pixel   (pix),
        .o_frame   (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h (x=%0d y=%0d frame=%0d mode=%0d)",
                     name, act, exp, m_x, m_y, m_frame, m_mode);
        end
    endtask

    function automatic logic [23:0] colour(input int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Pixel colour at screen position (x, y) from the pattern rules.
    function automatic logic [23:0] ref_pixel(input int md, input int x, input int y,
                                              input int fr, input int barw);
        int         bar;
        logic [7:0] v;
`ifdef VGATEST_BORDER_EN
        if (x == 0 || x == int'(width) - 1 || y == 0 || y == int'(height) - 1)
            return 24'hFFFFFF;
`endif
        case (md)
            0: begin
                bar = (barw == 0) ? 0 : x / barw;
                if (bar > 7) bar = 7;
                return colour(bar);
            end
            1: begin
                v = 8'((x + fr) % 256);
                return {v, v, v};
            end
            2: return ((((x / 16) + (y / 16) + fr) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            default: return colour(fr / 32);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        rd = 1'b0;
        nl = 1'b0;
        nf = 1'b0;
    endtask

    task automatic model_reset();
        m_frame = 0;
        m_mode  = 0;
        m_x     = 0;
        m_y     = 0;
        m_barw  = 0;
        m_dline = 1'b0;
        m_pix   = 24'h000000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_newframe(input int md);
        mode = 2'(md);
        nf   = 1'b1;
        tick();
        m_frame = (m_frame + 1) % 256;
        m_mode  = md;
        m_x     = 0;
        m_y     = 0;
        m_dline = 1'b0;
        m_barw  = int'(width) / 8;
        m_pix   = 24'h000000;
        chk("newframe_pixel", pix, m_pix);
        chk("newframe_count", {16'h0000, frame}, 24'(m_frame));
    endtask

    task automatic do_newline(input bit with_rd);
        nl = 1'b1;
        rd = with_rd;
        tick();
        if (m_dline) m_y++;
        m_x     = 0;
        m_dline = 1'b0;
        m_barw  = int'(width) / 8;
        m_pix   = 24'h000000;
        chk("newline_pixel", pix, m_pix);
    endtask

    task automatic do_rd();
        logic [23:0] exp;
        exp = ref_pixel(m_mode, m_x, m_y, m_frame, m_barw);
        rd  = 1'b1;
        tick();
        chk("rd_pixel", pix, exp);
        m_x++;
        m_dline = 1'b1;
        m_pix   = exp;
    endtask

    task automatic do_idle();
        tick();
        chk("idle_hold", pix, m_pix);
    endtask

    task automatic add_vec(input string name, input int md, input int fr, input int w,
                           input int x, input int y, input logic [23:0] exp);
        vec_t v;
        v.name = name; v.mode = md; v.frame = fr; v.width = w;
        v.x = x; v.y = y; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [23:0] exp;
        int          nrd;

        rst = 1'b0; width = 12'd640; height = 12'd480; mode = 2'd0;
        rd = 1'b0; nl = 1'b0; nf = 1'b0;
        model_reset();

        // Reset state
        rst = 1'b1;
        #2;
        chk("reset_pixel", pix, 24'h000000);
        chk("reset_frame", {16'h0000, frame}, 24'h000000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors: bars, ramp, checker, solid
        add_vec("bars_px79",    0,   1, 640,  79,  0, 24'hFFFFFF);
        add_vec("bars_px80",    0,   1, 640,  80,  0, 24'hFFFF00);
        add_vec("bars_px639",   0,   1, 640, 639,  0, 24'h000000);
        add_vec("bars_px300",   0,   1, 640, 300,  5, 24'h00FF00);
        add_vec("ramp_h10",     1,   3, 640,  10,  1, 24'h0D0D0D);
        add_vec("ramp_h255",    1,   3, 640, 255,  1, 24'h020202);
        add_vec("ramp_h300",    1,   3, 640, 300,  2, 24'h2F2F2F);
        add_vec("chk_e_15_0",   2,   2, 640,  15,  0, 24'h000000);
        add_vec("chk_e_16_0",   2,   2, 640,  16,  0, 24'hFFFFFF);
        add_vec("chk_e_16_16",  2,   2, 640,  16, 16, 24'h000000);
        add_vec("chk_o_15_0",   2,   3, 640,  15,  0, 24'hFFFFFF);
        add_vec("chk_o_16_16",  2,   3, 640,  16, 16, 24'hFFFFFF);
        add_vec("solid_f1",     3,   1, 640,   5,  3, 24'hFFFFFF);
        add_vec("solid_f32",    3,  32, 640,   5,  3, 24'hFFFF00);
        add_vec("solid_f200",   3, 200, 640,   5,  3, 24'h0000FF);
        add_vec("bars_narrow",  0,   1,   5,   4,  1, 24'hFFFFFF);

        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            width  = 12'(vecs[i].width);
            height = 12'd480;
            for (int f = 0; f < vecs[i].frame; f++) do_newframe(vecs[i].mode);
            for (int l = 0; l < vecs[i].y; l++) begin
                do_rd();
                do_newline(1'b0);
            end
            for (int p = 0; p < vecs[i].x; p++) do_rd();
            do_rd();
            exp = vecs[i].exp;
`ifdef VGATEST_BORDER_EN
            if (vecs[i].x == 0 || vecs[i].x == vecs[i].width - 1 ||
                vecs[i].y == 0 || vecs[i].y == 479)
                exp = 24'hFFFFFF;
`endif
            chk(vecs[i].name, pix, exp);
        end

        // Asynchronous reset mid-line at frame 5, then restart in bars mode
        do_reset();
        width = 12'd640;
        for (int f = 0; f < 5; f++) do_newframe(1);
        for (int p = 0; p < 3; p++) do_rd();
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_pixel", pix, 24'h000000);
        chk("async_reset_frame", {16'h0000, frame}, 24'h000000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        do_rd();
        chk("reset_restart_bars", pix, 24'hFFFFFF);

        // Mode change mid-frame keeps bars until the next newframe
        do_reset();
        width = 12'd640;
        do_newframe(0);
        do_rd();
        do_newline(1'b0);
        mode = 2'd2;
        for (int p = 0; p <= 100; p++) do_rd();
        chk("mode_change_held", pix, 24'hFFFF00);
        do_idle();
        do_idle();
        // newline with rd in the same cycle: newline wins, line restarts at 0
        do_newline(1'b1);
        chk("newline_rd_pixel", pix, 24'h000000);
        do_rd();
        do_rd();

        // Blank lines do not advance ypos (frame 2, checker)
        do_newframe(2);
        for (int l = 0; l < 15; l++) begin
            do_rd();
            do_newline(1'b0);
        end
        do_newline(1'b0);
        do_newline(1'b0);
        do_rd();
        do_rd();
        chk("blank_lines_y15", pix, 24'h000000);

        // Frame counter wraps 255 -> 0
        do_reset();
        for (int f = 0; f < 255; f++) do_newframe(3);
        chk("frame_255", {16'h0000, frame}, 24'h0000FF);
        do_newframe(3);
        chk("frame_wrap", {16'h0000, frame}, 24'h000000);

        // Randomized frames against the reference model
        for (int fr = 0; fr < 8; fr++) begin
            width  = (fr == 0) ? 12'd5 : 12'($urandom_range(16, 200));
            height = 12'($urandom_range(3, 8));
            do_newframe(int'($urandom_range(0, 3)));
            for (int l = 0; l < int'(height); l++) begin
                if ($urandom_range(0, 4) == 0) begin
                    do_newline(1'b0);
                end else begin
                    nrd = int'($urandom_range(1, int'(width)));
                    for (int p = 0; p < nrd; p++) begin
                        do_rd();
                        if ($urandom_range(0, 3) == 0) do_idle();
                    end
                    do_newline($urandom_range(0, 3) == 0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
